// File: rtl/timer_ctrl.sv
// timer_ctrl: run/pause/finish sequencer for a 4-digit MM:SS countdown built
// from a cascade of per-digit BCD down-counters.
//
// State table (one-hot):
//   state   | meaning
//   IDLE    | counters held in load state, presets editable, waiting for START
//   RUN     | counters enabled, watching for all-zero digits
//   PAUSE   | counters frozen, START resumes
//   FINISH  | alarm active, counters held finished until ACK or alarm timeout
//
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   START, CLEAR, INC_SEC, INC_MIN one-cycle button pulses
//   ACK                            alarm acknowledge pulse
//   CNT_BUSY                       OR of digit-counter BUSY outputs
//   VAL_S0/S1/M0/M1                live digit values from the counters
//   SET_S0/S1/M0/M1                BCD preset to the counters' VAL_SET
//   CNT_EN, CNT_DONE               shared counter controls
//   ALARM, ALARM_BLINK, RUNNING    status to display/LED logic
module timer_ctrl #(
    parameter int unsigned ALARM_CYC = 500_000_000,
    parameter int unsigned BLINK_CYC = 50_000_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       CLEAR,
    input  logic       INC_SEC,
    input  logic       INC_MIN,
    input  logic       ACK,
    input  logic       CNT_BUSY,
    input  logic [3:0] VAL_S0,
    input  logic [3:0] VAL_S1,
    input  logic [3:0] VAL_M0,
    input  logic [3:0] VAL_M1,
    output logic [3:0] SET_S0,
    output logic [3:0] SET_S1,
    output logic [3:0] SET_M0,
    output logic [3:0] SET_M1,
    output logic       CNT_EN,
    output logic       CNT_DONE,
    output logic       ALARM,
    output logic       ALARM_BLINK,
    output logic       RUNNING
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_RUN    = 4'b0010,
        ST_PAUSE  = 4'b0100,
        ST_FINISH = 4'b1000
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  set_s0_q, set_s0_d, set_s1_q, set_s1_d;
    logic [3:0]  set_m0_q, set_m0_d, set_m1_q, set_m1_d;
    logic        cnt_en_q, cnt_en_d, cnt_done_q, cnt_done_d;
    logic        alarm_q, alarm_d, blink_q, blink_d;
    logic [31:0] alarm_cnt_q, alarm_cnt_d, blink_cnt_q, blink_cnt_d;
    logic        val_zero_q, val_zero_d;

    logic [3:0]  sec0_inc, sec1_inc, min0_inc, min1_inc;
    logic        preset_nz;

    // BCD increments: seconds wrap 59 -> 00, minutes wrap 99 -> 00
    always_comb begin
        sec0_inc = (set_s0_q == 4'd9) ? 4'd0 : set_s0_q + 4'd1;
        sec1_inc = set_s1_q;
        if (set_s0_q == 4'd9)
            sec1_inc = (set_s1_q == 4'd5) ? 4'd0 : set_s1_q + 4'd1;
        min0_inc = (set_m0_q == 4'd9) ? 4'd0 : set_m0_q + 4'd1;
        min1_inc = set_m1_q;
        if (set_m0_q == 4'd9)
            min1_inc = (set_m1_q == 4'd9) ? 4'd0 : set_m1_q + 4'd1;
    end

    assign preset_nz = |{set_s0_q, set_s1_q, set_m0_q, set_m1_q};

    always_comb begin
        state_d     = state_q;
        set_s0_d    = set_s0_q;
        set_s1_d    = set_s1_q;
        set_m0_d    = set_m0_q;
        set_m1_d    = set_m1_q;
        cnt_done_d  = 1'b0;
        alarm_d     = 1'b0;
        blink_d     = 1'b0;
        alarm_cnt_d = 32'd0;
        blink_cnt_d = 32'd0;
        // registered copy of the all-zero compare; expiry is seen one cycle late
        val_zero_d  = (VAL_S0 == 4'd0) && (VAL_S1 == 4'd0) &&
                      (VAL_M0 == 4'd0) && (VAL_M1 == 4'd0);

        case (state_q)
            ST_IDLE: begin
                if (CLEAR) begin
                    set_s0_d = 4'd0;
                    set_s1_d = 4'd0;
                    set_m0_d = 4'd0;
                    set_m1_d = 4'd0;
                end else begin
                    if (INC_SEC) begin
                        set_s0_d = sec0_inc;
                        set_s1_d = sec1_inc;
                    end
                    if (INC_MIN) begin
                        set_m0_d = min0_inc;
                        set_m1_d = min1_inc;
                    end
                    if (START && !CNT_BUSY && preset_nz)
                        state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (CLEAR)
                    state_d = ST_IDLE;
                else if (val_zero_q) begin
                    state_d    = ST_FINISH;
                    cnt_done_d = 1'b1;
                end else if (START)
                    state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (CLEAR)
                    state_d = ST_IDLE;
                else if (START)
                    state_d = ST_RUN;
            end
            ST_FINISH: begin
                if (CLEAR || ACK || (alarm_cnt_q == 32'(ALARM_CYC - 1)))
                    state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                set_s0_d   = 4'd0;
                set_s1_d   = 4'd0;
                set_m0_d   = 4'd0;
                set_m1_d   = 4'd0;
                val_zero_d = 1'b0;
            end
        endcase

        // outputs are registered, so they are decoded from the next state
        cnt_en_d = (state_d == ST_RUN) || (state_d == ST_FINISH);
        if (state_d == ST_FINISH) begin
            alarm_d = 1'b1;
            if (state_q != ST_FINISH) begin
                blink_d = 1'b1;
            end else begin
                alarm_cnt_d = alarm_cnt_q + 32'd1;
                if (blink_cnt_q == 32'(BLINK_CYC - 1)) begin
                    blink_cnt_d = 32'd0;
                    blink_d     = ~blink_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 32'd1;
                    blink_d     = blink_q;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            set_s0_q    <= 4'd0;
            set_s1_q    <= 4'd0;
            set_m0_q    <= 4'd0;
            set_m1_q    <= 4'd0;
            cnt_en_q    <= 1'b0;
            cnt_done_q  <= 1'b0;
            alarm_q     <= 1'b0;
            blink_q     <= 1'b0;
            alarm_cnt_q <= 32'd0;
            blink_cnt_q <= 32'd0;
            val_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            set_s0_q    <= set_s0_d;
            set_s1_q    <= set_s1_d;
            set_m0_q    <= set_m0_d;
            set_m1_q    <= set_m1_d;
            cnt_en_q    <= cnt_en_d;
            cnt_done_q  <= cnt_done_d;
            alarm_q     <= alarm_d;
            blink_q     <= blink_d;
            alarm_cnt_q <= alarm_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            val_zero_q  <= val_zero_d;
        end
    end

    assign SET_S0      = set_s0_q;
    assign SET_S1      = set_s1_q;
    assign SET_M0      = set_m0_q;
    assign SET_M1      = set_m1_q;
    assign CNT_EN      = cnt_en_q;
    assign CNT_DONE    = cnt_done_q;
    assign ALARM       = alarm_q;
    assign ALARM_BLINK = blink_q;
    assign RUNNING     = (state_q == ST_RUN);

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed testbench for timer_ctrl with short alarm/blink periods.
module tb_timer_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0, CLEAR = 1'b0, INC_SEC = 1'b0, INC_MIN = 1'b0;
    logic       ACK = 1'b0, CNT_BUSY = 1'b0;
    logic [3:0] VAL_S0 = 4'd0, VAL_S1 = 4'd0, VAL_M0 = 4'd0, VAL_M1 = 4'd0;
    logic [3:0] SET_S0, SET_S1, SET_M0, SET_M1;
    logic       CNT_EN, CNT_DONE, ALARM, ALARM_BLINK, RUNNING;
    logic [15:0] set_all;

    int n_pass  = 0;
    int n_total = 0;

    assign set_all = {SET_M1, SET_M0, SET_S1, SET_S0};

    timer_ctrl #(.ALARM_CYC(20), .BLINK_CYC(4)) dut (
        .CLK(CLK), .RST(RST), .START(START), .CLEAR(CLEAR),
        .INC_SEC(INC_SEC), .INC_MIN(INC_MIN), .ACK(ACK), .CNT_BUSY(CNT_BUSY),
        .VAL_S0(VAL_S0), .VAL_S1(VAL_S1), .VAL_M0(VAL_M0), .VAL_M1(VAL_M1),
        .SET_S0(SET_S0), .SET_S1(SET_S1), .SET_M0(SET_M0), .SET_M1(SET_M1),
        .CNT_EN(CNT_EN), .CNT_DONE(CNT_DONE), .ALARM(ALARM),
        .ALARM_BLINK(ALARM_BLINK), .RUNNING(RUNNING)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_en"},    16'(CNT_EN), 16'd0);
        chk({tag, "_done"},  16'(CNT_DONE), 16'd0);
        chk({tag, "_alarm"}, 16'(ALARM), 16'd0);
        chk({tag, "_blink"}, 16'(ALARM_BLINK), 16'd0);
        chk({tag, "_run"},   16'(RUNNING), 16'd0);
    endtask

    task automatic press_start();
        START = 1'b1; tick(); START = 1'b0;
    endtask
    task automatic press_clear();
        CLEAR = 1'b1; tick(); CLEAR = 1'b0;
    endtask
    task automatic press_sec(input int n);
        for (int i = 0; i < n; i++) begin
            INC_SEC = 1'b1; tick(); INC_SEC = 1'b0;
        end
    endtask
    task automatic press_min(input int n);
        for (int i = 0; i < n; i++) begin
            INC_MIN = 1'b1; tick(); INC_MIN = 1'b0;
        end
    endtask

    logic [19:0] blink_pat;

    initial begin
        blink_pat = 20'b1111_0000_1111_0000_1111;

        // reset
        tick(); tick();
        RST = 1'b0;
        tick();
        chk("rst_set", set_all, 16'h0000);
        chk_idle_outs("rst");

        // preset editing and wraps
        press_sec(59);
        chk("sec_59", set_all, 16'h0059);
        press_sec(2);
        press_min(3);
        chk("preset_0301", set_all, 16'h0301);
        press_clear();
        chk("clear_idle", set_all, 16'h0000);
        press_min(99);
        chk("min_99", set_all, 16'h9900);
        press_min(1);
        chk("min_wrap", set_all, 16'h0000);

        // START with zero preset is dropped
        press_start();
        chk("start_zero_en", 16'(CNT_EN), 16'd0);
        chk("start_zero_run", 16'(RUNNING), 16'd0);

        // START while counters busy is dropped, not queued
        press_sec(5);
        CNT_BUSY = 1'b1;
        press_start();
        chk("start_busy_en", 16'(CNT_EN), 16'd0);
        CNT_BUSY = 1'b0;
        tick();
        chk("busy_noqueue_en", 16'(CNT_EN), 16'd0);

        // run 00:03 with pause/resume, then expire
        press_clear();
        press_sec(3);
        chk("preset_0003", set_all, 16'h0003);
        VAL_S0 = 4'd3;
        press_start();
        chk("run_en", 16'(CNT_EN), 16'd1);
        chk("run_running", 16'(RUNNING), 16'd1);
        VAL_S0 = 4'd2;
        tick();
        press_start();
        chk("pause_en", 16'(CNT_EN), 16'd0);
        chk("pause_running", 16'(RUNNING), 16'd0);
        INC_SEC = 1'b1; tick(); INC_SEC = 1'b0;
        chk("pause_set_kept", set_all, 16'h0003);
        press_start();
        chk("resume_en", 16'(CNT_EN), 16'd1);
        chk("resume_running", 16'(RUNNING), 16'd1);
        VAL_S0 = 4'd1;
        tick();
        VAL_S0 = 4'd0;
        tick();
        chk("zero_seen_done", 16'(CNT_DONE), 16'd0);
        chk("zero_seen_alarm", 16'(ALARM), 16'd0);
        tick();
        // FINISH cycle 1 onward: no ACK, auto-return after 20 cycles
        for (int k = 1; k <= 20; k++) begin
            chk("fin_alarm", 16'(ALARM), 16'd1);
            chk("fin_en", 16'(CNT_EN), 16'd1);
            chk("fin_blink", 16'(ALARM_BLINK), 16'(blink_pat[20-k]));
            chk("fin_done", 16'(CNT_DONE), (k == 1) ? 16'd1 : 16'd0);
            tick();
        end
        chk_idle_outs("auto_idle");
        chk("auto_idle_set", set_all, 16'h0003);

        // second expiry, ACK on FINISH cycle 5
        VAL_S0 = 4'd3;
        tick();
        press_start();
        chk("run2_en", 16'(CNT_EN), 16'd1);
        VAL_S0 = 4'd0;
        tick();
        tick();
        chk("fin2_alarm", 16'(ALARM), 16'd1);
        tick(); tick(); tick(); tick();
        chk("fin2_c5_alarm", 16'(ALARM), 16'd1);
        chk("fin2_c5_blink", 16'(ALARM_BLINK), 16'd0);
        ACK = 1'b1; tick(); ACK = 1'b0;
        chk_idle_outs("ack_idle");

        // START and CLEAR together in RUN: CLEAR wins, preset kept
        VAL_S0 = 4'd3;
        tick();
        press_start();
        chk("run3_running", 16'(RUNNING), 16'd1);
        START = 1'b1; CLEAR = 1'b1; tick(); START = 1'b0; CLEAR = 1'b0;
        chk_idle_outs("clr_start");
        chk("clr_start_set", set_all, 16'h0003);
        press_clear();
        chk("clr2_set", set_all, 16'h0000);

        // reset in RUN with expiry pending
        press_sec(1);
        VAL_S0 = 4'd1;
        tick();
        press_start();
        chk("run4_running", 16'(RUNNING), 16'd1);
        VAL_S0 = 4'd0;
        tick();
        RST = 1'b1; tick();
        chk_idle_outs("rst_run");
        chk("rst_run_set", set_all, 16'h0000);
        RST = 1'b0; tick();
        chk_idle_outs("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Run/pause/finish controller for a 4-digit MM:SS countdown timer built from a cascade of per-digit down-counters.
- Owns the BCD preset registers and drives the shared EN/DONE/VAL_SET controls of all digit counters.
- Watches the live digit values to detect expiry, raises an alarm, then returns the counters to their load state.
- Sits between the debounced button pulses and the counter bank; feeds status to the display/LED logic.

Parameters:
- ALARM_CYC, 500_000_000, CLK cycles ALARM stays high before auto-return to IDLE.
- BLINK_CYC, 50_000_000, CLK cycles per half-period of ALARM_BLINK.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- START  in  1  one-cycle pulse: start / pause / resume
- CLEAR  in  1  one-cycle pulse: abort to IDLE; zeroes preset when already in IDLE
- INC_SEC  in  1  one-cycle pulse: preset seconds +1 (IDLE only)
- INC_MIN  in  1  one-cycle pulse: preset minutes +1 (IDLE only)
- ACK  in  1  one-cycle pulse: acknowledge alarm
- CNT_BUSY  in  1  OR of digit-counter BUSY outputs
- VAL_S0, VAL_S1, VAL_M0, VAL_M1  in  4 each  live digit values: sec ones, sec tens, min ones, min tens
- SET_S0, SET_S1, SET_M0, SET_M1  out  4 each  preset BCD digits to the counters' VAL_SET
- CNT_EN  out  1  EN to all digit counters
- CNT_DONE  out  1  DONE to all digit counters
- ALARM  out  1  high in FINISH
- ALARM_BLINK  out  1  square wave while in FINISH, else 0
- RUNNING  out  1  high in RUN

Behaviour:
- Reset: state IDLE; all SET_* = 0; CNT_EN = 0, CNT_DONE = 0, ALARM = 0, ALARM_BLINK = 0, RUNNING = 0; both internal counters = 0. Reset mid-operation aborts immediately with the same values.
- States are one-hot: IDLE, RUN, PAUSE, FINISH. Any illegal encoding goes to IDLE with reset values.
- CLEAR has top priority in every state: next state is IDLE, with CNT_EN = 0 and CNT_DONE = 0 on the following cycle.
  - CLEAR in IDLE also zeroes all SET_*.
  - CLEAR together with START: CLEAR wins.
- IDLE:
  - CNT_EN = 0.
  - INC_SEC: seconds preset {SET_S1,SET_S0} counts BCD 00..59 and wraps 59 -> 00.
  - INC_MIN: {SET_M1,SET_M0} counts BCD 00..99 and wraps 99 -> 00.
  - INC_SEC and INC_MIN in the same cycle: both apply.
  - START is accepted only when CNT_BUSY = 0 and the preset is non-zero. Then next state is RUN and CNT_EN = 1 from the next cycle.
  - A START that fails either condition is dropped, not queued.
- RUN:
  - CNT_EN = 1, RUNNING = 1.
  - Expiry: all four VAL_* == 0, compared from registered copies, so detection is one cycle after the digits reach zero. On expiry, CNT_DONE = 1 for exactly one cycle and the next state is FINISH.
  - START (no expiry): next state PAUSE, CNT_EN = 0 next cycle.
  - Expiry and START in the same cycle: expiry wins.
  - INC_* ignored.
- PAUSE:
  - CNT_EN = 0, RUNNING = 0, SET_* unchanged.
  - START returns to RUN.
  - Expiry is not checked.
- FINISH:
  - CNT_EN is held at 1 so the counters stay in their finished state. ALARM = 1.
  - ALARM_BLINK toggles every BLINK_CYC cycles, starting at 1 on entry.
  - ACK, or the alarm counter reaching ALARM_CYC-1: next state IDLE, CNT_EN = 0, ALARM = 0. The counters then reload from SET_*, so the preset is retained.
  - START and INC_* are ignored.
- Alarm and blink counters are 32-bit, cleared on every FINISH entry, and held at 0 outside FINISH.
- Outputs are registered, except RUNNING, which is decoded from the state register.

Test Plan:
- Reset, then 61×INC_SEC and 3×INC_MIN -> SET = M1:0 M0:3 S1:0 S0:1; 100×INC_MIN from 00 -> minutes wrap back to 00.
- START with preset 00:00 -> stays IDLE, CNT_EN stays 0; START with CNT_BUSY = 1 and preset 00:05 -> ignored.
- Preset 00:03, START -> CNT_EN = 1 next cycle. Model drives the digits 3,2,1,0 -> CNT_DONE is a 1-cycle pulse one cycle after all-zero, ALARM = 1, CNT_EN stays 1.
- In RUN, START -> PAUSE with CNT_EN = 0; START again -> RUN. START and CLEAR in the same cycle -> IDLE, preset kept; a second CLEAR -> all SET_* = 0.
- FINISH with ALARM_CYC = 20, BLINK_CYC = 4 and no ACK -> ALARM_BLINK pattern 1111 0000 ..., auto-IDLE after 20 cycles; repeat with ACK on cycle 5 -> IDLE next cycle, CNT_EN = 0.
- Assert RST in RUN with expiry pending -> all outputs return to reset values next cycle, and no CNT_DONE pulse.
